// File: rtl/xnor_arb_pkg.sv
// Shared types and helpers for controllers that time-share one xnor_gate.
// Holds the FSM state type, the counter width and the round-robin search.
package xnor_arb_pkg;

    typedef enum logic [1:0] {IDLE, EVAL, RESP} arb_state_t;

    localparam int TXN_W   = 8;
    localparam int MAX_REQ = 16;
    localparam int IDX_W   = 4;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Scan upward from ptr, modulo n, and return the first valid index.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [IDX_W-1:0]   ptr,
                                      input int                 n);
        pick_t            r;
        int               pos;
        logic [IDX_W-1:0] sel;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            pos = (int'(ptr) + k) % n;
            sel = pos[IDX_W-1:0];
            if (k < n && !r.found && valid[sel]) begin
                r.found = 1'b1;
                r.idx   = sel;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: one-hot grant plus index for the first
// valid requester at or after rr_ptr.
module rr_picker
    import xnor_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]  grant_idx,
    output logic             grant_found
);

    logic [MAX_REQ-1:0] valid_ext;
    logic [IDX_W-1:0]   ptr_ext;
    pick_t              pick;

    always_comb begin
        valid_ext                = '0;
        valid_ext[N_REQ-1:0]     = req_valid;
        ptr_ext                  = '0;
        ptr_ext[ID_W-1:0]        = rr_ptr;
        pick                     = rr_pick(valid_ext, ptr_ext, N_REQ);
        grant_found              = pick.found;
        grant_idx                = pick.idx[ID_W-1:0];
        grant_onehot             = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_onehot[i] = pick.found && (pick.idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/xnor_gate_arbiter.sv
// Round-robin sequencer sharing one external xnor_gate between N_REQ
// requesters; returns each result tagged with the requester index.
module xnor_gate_arbiter
    import xnor_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_valid,
    input  logic [N_REQ-1:0] req_a,
    input  logic [N_REQ-1:0] req_b,
    output logic [N_REQ-1:0] req_ready,
    output logic             gate_a,
    output logic             gate_b,
    input  logic             gate_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ID_W-1:0]  rsp_id,
    output logic             rsp_y,
    output logic [TXN_W-1:0] txn_count
);

    arb_state_t       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [N_REQ-1:0] grant_onehot;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_found;
    logic             accept;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req_valid    (req_valid),
        .rr_ptr       (rr_ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .grant_found  (grant_found)
    );

    // The picked index is always a valid requester, so a find is an accept.
    assign accept    = (state == IDLE) && grant_found && !rst;
    assign req_ready = accept ? grant_onehot : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gate_a    <= 1'b0;
            gate_b    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= 1'b0;
            txn_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        gate_a <= req_a[grant_idx];
                        gate_b <= req_b[grant_idx];
                        rsp_id <= grant_idx;
                        state  <= EVAL;
                    end
                end
                EVAL: begin
                    rsp_y     <= gate_y;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (rsp_id == ID_W'(N_REQ - 1)) ? '0 : rsp_id + 1'b1;
                        txn_count <= txn_count + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xnor_gate_arbiter.sv
// Bench for xnor_gate_arbiter: directed vector table, corner sequences and a
// randomized run checked against a transaction-level reference.
module tb_xnor_gate_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid, req_a, req_b, req_ready;
    logic       gate_a, gate_b, gate_y;
    logic       rsp_valid, rsp_ready, rsp_y;
    logic [1:0] rsp_id;
    logic [7:0] txn_count;

    always #5 clk = ~clk;

    // The shared gate lives beside the arbiter.
    assign gate_y = ~(gate_a ^ gate_b);

    xnor_gate_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .gate_a    (gate_a),
        .gate_b    (gate_b),
        .gate_y    (gate_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .txn_count (txn_count)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] a;
        logic [3:0] b;
        int         id;
        int         y;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_winner(input logic [3:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic do_txn(input vec_t v, input int cnt_after);
        req_valid = v.valid;
        req_a     = v.a;
        req_b     = v.b;
        rsp_ready = 1'b1;
        #1;
        chk("grant", int'(req_ready), 1 << v.id);
        tick();
        req_valid = '0;
        chk("gate_a", int'(gate_a), int'(v.a[v.id]));
        chk("gate_b", int'(gate_b), int'(v.b[v.id]));
        chk("eval_rsp_valid", int'(rsp_valid), 0);
        tick();
        chk("rsp_valid", int'(rsp_valid), 1);
        chk("rsp_id", int'(rsp_id), v.id);
        chk("rsp_y", int'(rsp_y), v.y);
        tick();
        chk("rsp_done", int'(rsp_valid), 0);
        chk("txn_count", int'(txn_count), cnt_after);
    endtask

    initial begin
        bit [3:0] pend;
        bit [3:0] pa, pb;
        int       ptr, exp_count, busy, age, w, exp_id;
        int       exp_a, exp_b, exp_y;

        vecs[0] = '{4'b0001, 4'b0000, 4'b0000, 0, 1};
        vecs[1] = '{4'b0001, 4'b0001, 4'b0000, 0, 0};
        vecs[2] = '{4'b0001, 4'b0000, 4'b0001, 0, 0};
        vecs[3] = '{4'b0001, 4'b0001, 4'b0001, 0, 1};
        vecs[4] = '{4'b1111, 4'b1111, 4'b1111, 1, 1};
        vecs[5] = '{4'b1111, 4'b1111, 4'b1111, 2, 1};
        vecs[6] = '{4'b1111, 4'b1111, 4'b1111, 3, 1};
        vecs[7] = '{4'b1111, 4'b1111, 4'b1111, 0, 1};
        vecs[8] = '{4'b1000, 4'b1000, 4'b0000, 3, 0};
        vecs[9] = '{4'b1111, 4'b0000, 4'b0000, 0, 1};

        // Reset with every requester asking
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = 4'b1111;
        req_b     = 4'b1111;
        rsp_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_req_ready", int'(req_ready), 0);
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_txn_count", int'(txn_count), 0);
            chk("rst_gate_a", int'(gate_a), 0);
            chk("rst_gate_b", int'(gate_b), 0);
        end
        rst       = 1'b0;
        req_valid = '0;

        for (int i = 0; i < 10; i++) do_txn(vecs[i], i + 1);

        // Backpressure on requester 1 (pointer sits at 1)
        req_valid = 4'b0010;
        req_a     = 4'b0010;
        req_b     = 4'b0000;
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant", int'(req_ready), 4'b0010);
        tick();
        req_valid = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", int'(rsp_valid), 1);
            chk("bp_rsp_id", int'(rsp_id), 1);
            chk("bp_rsp_y", int'(rsp_y), 0);
            chk("bp_req_ready", int'(req_ready), 0);
            chk("bp_txn_count", int'(txn_count), 10);
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        chk("bp_hold_last", int'(rsp_valid), 1);
        tick();
        chk("bp_done_valid", int'(rsp_valid), 0);
        chk("bp_done_count", int'(txn_count), 11);

        // Reset while in EVAL drops the transaction
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = 4'b0100;
        req_a     = 4'b0000;
        req_b     = 4'b0000;
        #1;
        chk("mid_grant", int'(req_ready), 4'b0100);
        tick();
        req_valid = '0;
        rst       = 1'b1;
        #1;
        chk("mid_rst_ready", int'(req_ready), 0);
        tick();
        chk("mid_rsp_valid", int'(rsp_valid), 0);
        chk("mid_txn_count", int'(txn_count), 0);
        rst = 1'b0;
        tick();
        chk("mid_no_pulse", int'(rsp_valid), 0);
        req_valid = 4'b1111;
        #1;
        chk("mid_next_grant", int'(req_ready), 4'b0001);
        tick();
        req_valid = '0;
        tick();
        chk("mid_rsp_id", int'(rsp_id), 0);
        chk("mid_rsp_y", int'(rsp_y), 1);
        tick();
        chk("mid_txn_after", int'(txn_count), 1);

        // Randomized traffic against a transaction-level model
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        pend      = '0;
        pa        = '0;
        pb        = '0;
        ptr       = 0;
        exp_count = 0;
        busy      = 0;
        age       = 0;
        exp_id    = 0;
        exp_a     = 0;
        exp_b     = 0;
        exp_y     = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i] = 1'b1;
                    pa[i]   = 1'($urandom);
                    pb[i]   = 1'($urandom);
                end
            end
            req_valid = pend;
            req_a     = pa;
            req_b     = pb;
            rsp_ready = ($urandom % 4) != 0;
            #1;
            if (busy != 0) age++;
            chk("r_txn_count", int'(txn_count), exp_count % 256);
            chk("r_rsp_valid", int'(rsp_valid), (busy != 0 && age >= 2) ? 1 : 0);
            if (busy != 0) begin
                chk("r_req_ready_busy", int'(req_ready), 0);
                if (age == 1) begin
                    chk("r_gate_a", int'(gate_a), exp_a);
                    chk("r_gate_b", int'(gate_b), exp_b);
                end
                if (age >= 2) begin
                    chk("r_rsp_id", int'(rsp_id), exp_id);
                    chk("r_rsp_y", int'(rsp_y), exp_y);
                    if (rsp_ready) begin
                        busy = 0;
                        ptr  = (exp_id + 1) % N;
                        exp_count++;
                    end
                end
            end else begin
                w = exp_winner(req_valid, ptr);
                chk("r_grant", int'(req_ready), (w < 0) ? 0 : (1 << w));
                if (w >= 0) begin
                    busy    = 1;
                    age     = 0;
                    exp_id  = w;
                    exp_a   = int'(pa[w]);
                    exp_b   = int'(pb[w]);
                    exp_y   = (exp_a == exp_b) ? 1 : 0;
                    pend[w] = 1'b0;
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xnor_gate_arbiter.md
# xnor_gate_arbiter

Round-robin controller that shares a single `xnor_gate` instance between `N_REQ` requesters. Each requester offers one operand pair (a, b) over a valid/ready handshake. The controller grants one requester, drives the shared gate, and samples its output. It then returns the result with the requester ID over a valid/ready response channel. The `xnor_gate` instance sits in the parent, beside this block; this block owns only the sequencing.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `ID_W`, default `$clog2(N_REQ)`: width of requester ID; derived, not overridden.
- `clk`  in  1: single clock; everything is on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req_valid`  in  N_REQ: bit i means requester i offers an operand pair.
- `req_a`  in  N_REQ: bit i is operand a of requester i.
- `req_b`  in  N_REQ: bit i is operand b of requester i.
- `req_ready`  out  N_REQ: one-hot grant; bit i high means the pair is accepted this cycle.
- `gate_a`  out  1: registered operand a to the shared `xnor_gate`.
- `gate_b`  out  1: registered operand b to the shared `xnor_gate`.
- `gate_y`  in  1: output of the shared `xnor_gate`.
- `rsp_valid`  out  1: response available.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_id`  out  ID_W: index of the requester served.
- `rsp_y`  out  1: sampled XNOR result.
- `txn_count`  out  8: completed responses; wraps 255→0.

## Operation
- FSM states: IDLE, EVAL, RESP.
- **IDLE**
  - Search starts at `rr_ptr` and scans upward modulo N_REQ. The first i with `req_valid[i]=1` wins.
  - If there is a winner, `req_ready` = one-hot(i) combinationally in the same cycle. Acceptance is `req_valid[i] & req_ready[i]`.
  - On acceptance: `gate_a`←`req_a[i]`, `gate_b`←`req_b[i]`, `rsp_id`←i, then go to EVAL.
  - If there is no winner, `req_ready`=0 and the FSM stays in IDLE.
- **EVAL**
  - `req_ready`=0.
  - `rsp_y`←`gate_y`, `rsp_valid`←1, then go to RESP.
- **RESP**
  - `rsp_valid`, `rsp_id` and `rsp_y` stay stable until `rsp_ready`=1.
  - On the handshake: `rsp_valid`←0, `rr_ptr`←(`rsp_id`+1) mod N_REQ, `txn_count`←`txn_count`+1, then go to IDLE.
- `req_ready` is 0 in EVAL and RESP and whenever `rst`=1. Requesters hold `valid` and their operands until accepted.
- `gate_a` and `gate_b` hold their last values outside acceptance.
- **Reset values:** state IDLE, `rr_ptr`=0, `gate_a`=0, `gate_b`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_y`=0, `txn_count`=0, `req_ready`=0.
- **Reset mid-transaction** (EVAL or RESP): the transaction is dropped. No response is issued and `txn_count` is not incremented.
- **Pointer wrap:** serving index N_REQ-1 sets `rr_ptr`=0.
- **All requesters valid:** grants rotate 0,1,…,N_REQ-1,0. No requester waits more than N_REQ-1 grants.
- `rsp_ready` held high while in IDLE or EVAL has no effect.

## Timing
- Accept at edge T: `gate_a`/`gate_b` are valid after T, and `gate_y` is sampled at T+1.
- `rsp_valid` first rises after edge T+1, so the response is visible in cycle T+2.
- Best-case throughput is one transaction per 3 cycles, with `rsp_ready` held high.
- There is no combinational path from `gate_y` to any output; `rsp_y` is registered.
- The only combinational input→output path is `req_valid`→`req_ready`.

## Structure
- Package `xnor_arb_pkg` holds:
  - the state enum `arb_state_t` {IDLE, EVAL, RESP};
  - the constant `TXN_W`=8;
  - the function `rr_pick(valid, ptr)`, which returns the winner index and a found flag.
- Sub-module `rr_picker` is purely combinational. It is parameterised by `N_REQ`, takes `req_valid` and `rr_ptr`, and produces `grant_onehot`, `grant_idx` and `grant_found`. It is reusable by other shared-gate controllers.
- The top level holds the FSM, the operand/response registers and the counter.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `req_valid`=4'b1111 → `req_ready`=0, `rsp_valid`=0, `txn_count`=0, `gate_a`=`gate_b`=0.
- **Truth table on requester 0:** sequence (a,b) = (0,0),(1,0),(0,1),(1,1) with `rsp_ready`=1 → `rsp_y`=1,0,0,1, `rsp_id`=0, each response 2 cycles after acceptance; `txn_count`=4 at the end.
- **Fairness:** `req_valid`=4'b1111 constant, operands (1,1) on all → `rsp_id` sequence 0,1,2,3,0,1; `rr_ptr` wraps 3→0.
- **Backpressure:** `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, `rsp_id` and `rsp_y` stable, `req_ready`=0 throughout; the response completes on the cycle `rsp_ready`=1.
- **Skip:** `rr_ptr`=1 and only requester 3 valid with (1,0) → granted immediately, `rsp_id`=3, `rsp_y`=0, next `rr_ptr`=0.
- **Mid-op reset:** assert `rst` in EVAL → no `rsp_valid` pulse, `txn_count` unchanged at 0, next grant goes to requester 0.
